// File: rtl/rx_lbuf_sched.sv
// Receive lbuf scheduler: queues host-posted 4 KiB-aligned buffer addresses
// and hands them out alternately to two receive slots.
module rx_lbuf_sched #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          post_addr,
  input  logic                 post_valid,
  input  logic                 flush,
  input  logic                 clr_err,
  output logic [63:0]          lbuf1_addr,
  output logic                 lbuf1_en,
  input  logic                 lbuf1_dn,
  output logic [63:0]          lbuf2_addr,
  output logic                 lbuf2_en,
  input  logic                 lbuf2_dn,
  output logic [FIFO_AW:0]     pending,
  output logic [31:0]          done_cnt,
  output logic                 ovf_err,
  output logic                 aln_err
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic {
    S_FREE  = 1'b0,
    S_ARMED = 1'b1
  } slot_t;

  logic [63:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CW-1:0]      r_pending;
  slot_t              r_st1;
  slot_t              r_st2;
  logic               r_nxt;   // 0 selects slot1, 1 selects slot2
  logic [63:0]        r_addr1;
  logic [63:0]        r_addr2;
  logic               r_en1;
  logic               r_en2;
  logic [31:0]        r_done;
  logic               r_ovf;
  logic               r_aln;

  logic               w_aligned;
  logic               w_nonempty;
  logic               w_full;
  logic               w_arm1;
  logic               w_arm2;
  logic               w_pop;
  logic               w_push;
  logic               w_aln_set;
  logic               w_ovf_set;
  logic               w_fin1;
  logic               w_fin2;
  logic [63:0]        w_head;

  // Accept/arm decisions all use registered state, so a post never bypasses the FIFO.
  always_comb begin
    w_aligned  = (post_addr[11:0] == 12'h000);
    w_nonempty = (r_pending != CW'(0));
    w_full     = (r_pending == CW'(DEPTH));
    w_arm1     = !flush && w_nonempty && !r_nxt && (r_st1 == S_FREE);
    w_arm2     = !flush && w_nonempty &&  r_nxt && (r_st2 == S_FREE);
    w_pop      = w_arm1 || w_arm2;
    w_push     = post_valid && w_aligned && !flush && (!w_full || w_pop);
    w_aln_set  = post_valid && !w_aligned && !flush;
    w_ovf_set  = post_valid && w_aligned && !flush && w_full && !w_pop;
    w_fin1     = lbuf1_dn && (r_st1 == S_ARMED);
    w_fin2     = lbuf2_dn && (r_st2 == S_ARMED);
    w_head     = r_mem[r_rd_ptr];
  end

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= post_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
    end else if (flush) begin
      r_rd_ptr  <= r_wr_ptr;
      r_pending <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_pending <= r_pending + CW'(w_push) - CW'(w_pop);
    end
  end

  // Per-slot FREE/ARMED machines with the alternating next-slot pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st1   <= S_FREE;
      r_st2   <= S_FREE;
      r_nxt   <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_en1   <= 1'b0;
      r_en2   <= 1'b0;
    end else begin
      case (r_st1)
        S_FREE: if (w_arm1) begin
          r_st1   <= S_ARMED;
          r_addr1 <= w_head;
          r_en1   <= 1'b1;
        end
        S_ARMED: if (w_fin1) begin
          r_st1 <= S_FREE;
          r_en1 <= 1'b0;
        end
        default: r_st1 <= S_FREE;
      endcase
      case (r_st2)
        S_FREE: if (w_arm2) begin
          r_st2   <= S_ARMED;
          r_addr2 <= w_head;
          r_en2   <= 1'b1;
        end
        S_ARMED: if (w_fin2) begin
          r_st2 <= S_FREE;
          r_en2 <= 1'b0;
        end
        default: r_st2 <= S_FREE;
      endcase
      if (w_pop) r_nxt <= !r_nxt;
    end
  end

  // Completion counter and sticky error flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= '0;
      r_ovf  <= 1'b0;
      r_aln  <= 1'b0;
    end else begin
      r_done <= r_done + 32'(w_fin1) + 32'(w_fin2);
      r_ovf  <= w_ovf_set || (r_ovf && !clr_err);
      r_aln  <= w_aln_set || (r_aln && !clr_err);
    end
  end

  assign lbuf1_addr = r_addr1;
  assign lbuf1_en   = r_en1;
  assign lbuf2_addr = r_addr2;
  assign lbuf2_en   = r_en2;
  assign pending    = r_pending;
  assign done_cnt   = r_done;
  assign ovf_err    = r_ovf;
  assign aln_err    = r_aln;

endmodule

// File: tb/tb_rx_lbuf_sched.sv
// Bench for rx_lbuf_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_lbuf_sched;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   post_addr;
  logic          post_valid;
  logic          flush;
  logic          clr_err;
  logic [63:0]   lbuf1_addr;
  logic          lbuf1_en;
  logic          lbuf1_dn;
  logic [63:0]   lbuf2_addr;
  logic          lbuf2_en;
  logic          lbuf2_dn;
  logic [AW:0]   pending;
  logic [31:0]   done_cnt;
  logic          ovf_err;
  logic          aln_err;

  rx_lbuf_sched #(.FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .post_addr(post_addr), .post_valid(post_valid),
    .flush(flush), .clr_err(clr_err),
    .lbuf1_addr(lbuf1_addr), .lbuf1_en(lbuf1_en), .lbuf1_dn(lbuf1_dn),
    .lbuf2_addr(lbuf2_addr), .lbuf2_en(lbuf2_en), .lbuf2_dn(lbuf2_dn),
    .pending(pending), .done_cnt(done_cnt),
    .ovf_err(ovf_err), .aln_err(aln_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: plain queue plus per-slot busy bits.
  logic [63:0] q[$];
  bit          m_en1, m_en2, m_nxt, m_ovf, m_aln, m_live;
  logic [63:0] m_addr1, m_addr2;
  int unsigned m_done;

  always @(posedge clk) begin
    bit f1, f2;
    if (rst) begin
      q.delete();
      m_en1 = 0; m_en2 = 0; m_nxt = 0; m_ovf = 0; m_aln = 0;
      m_addr1 = '0; m_addr2 = '0; m_done = 0; m_live = 1;
    end else begin
      f1 = m_en1 && lbuf1_dn;
      f2 = m_en2 && lbuf2_dn;
      if (clr_err) begin m_ovf = 0; m_aln = 0; end
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && !m_nxt && !m_en1) begin
          m_addr1 = q.pop_front(); m_en1 = 1; m_nxt = 1;
        end else if (q.size() > 0 && m_nxt && !m_en2) begin
          m_addr2 = q.pop_front(); m_en2 = 1; m_nxt = 0;
        end
        if (post_valid) begin
          if (post_addr[11:0] != 12'h000) m_aln = 1;
          else if (q.size() < DEPTH) q.push_back(post_addr);
          else m_ovf = 1;
        end
      end
      if (f1) m_en1 = 0;
      if (f2) m_en2 = 0;
      m_done = m_done + 32'(f1) + 32'(f2);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("en1",     64'(lbuf1_en),   64'(m_en1));
      chk("en2",     64'(lbuf2_en),   64'(m_en2));
      chk("addr1",   lbuf1_addr,      m_addr1);
      chk("addr2",   lbuf2_addr,      m_addr2);
      chk("pending", 64'(pending),    64'(q.size()));
      chk("done",    64'(done_cnt),   64'(m_done));
      chk("ovf",     64'(ovf_err),    64'(m_ovf));
      chk("aln",     64'(aln_err),    64'(m_aln));
    end
  end

  task automatic cyc(input logic pv, input logic [63:0] a, input logic fl,
                     input logic cl, input logic d1, input logic d2, input logic r);
    post_valid = pv; post_addr = a; flush = fl; clr_err = cl;
    lbuf1_dn = d1; lbuf2_dn = d2; rst = r;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 64'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic post(input logic [63:0] a);
    cyc(1, a, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_live = 0;
    rst = 1; post_valid = 0; post_addr = '0; flush = 0; clr_err = 0;
    lbuf1_dn = 0; lbuf2_dn = 0;
    @(negedge clk);
    cyc(0, 64'h0, 0, 0, 0, 0, 1);
    chk("rst_en1", 64'(lbuf1_en), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_done", 64'(done_cnt), 64'h0);

    // Two posts: slot1 then slot2, pending drains.
    post(64'h1000);
    chk("a_pend1", 64'(pending), 64'h1);
    chk("a_en1_early", 64'(lbuf1_en), 64'h0);
    post(64'h2000);
    chk("a_en1", 64'(lbuf1_en), 64'h1);
    chk("a_addr1", lbuf1_addr, 64'h1000);
    idle();
    chk("a_en2", 64'(lbuf2_en), 64'h1);
    chk("a_addr2", lbuf2_addr, 64'h2000);
    chk("a_pend0", 64'(pending), 64'h0);

    // Overflow with both slots armed.
    post(64'h10000); post(64'h20000); post(64'h30000); post(64'h40000); post(64'h50000);
    chk("b_pend", 64'(pending), 64'h4);
    chk("b_ovf", 64'(ovf_err), 64'h1);
    cyc(0, 64'h0, 0, 1, 0, 0, 0);
    chk("c_ovf_clr", 64'(ovf_err), 64'h0);
    post(64'h1008);
    chk("c_aln", 64'(aln_err), 64'h1);
    chk("c_pend", 64'(pending), 64'h4);
    cyc(0, 64'h0, 0, 1, 0, 0, 0);
    chk("c_aln_clr", 64'(aln_err), 64'h0);

    // Simultaneous completions, then re-arm in order.
    cyc(0, 64'h0, 0, 0, 1, 1, 0);
    chk("d_done2", 64'(done_cnt), 64'h2);
    chk("d_en1_off", 64'(lbuf1_en), 64'h0);
    idle();
    chk("d_addr1", lbuf1_addr, 64'h10000);
    chk("d_en2_off", 64'(lbuf2_en), 64'h0);
    idle();
    chk("d_addr2", lbuf2_addr, 64'h20000);
    chk("d_pend", 64'(pending), 64'h2);

    // Flush with a same-cycle post while three are queued.
    post(64'h60000);
    chk("e_pend3", 64'(pending), 64'h3);
    cyc(1, 64'h70000, 1, 0, 0, 0, 0);
    chk("e_pend0", 64'(pending), 64'h0);
    chk("e_en1", 64'(lbuf1_en), 64'h1);
    chk("e_flags", 64'({ovf_err, aln_err}), 64'h0);

    // Slot1 completes, gets the next post.
    cyc(0, 64'h0, 0, 0, 1, 0, 0);
    chk("f_done3", 64'(done_cnt), 64'h3);
    post(64'h3000);
    idle();
    chk("f_addr1", lbuf1_addr, 64'h3000);
    chk("f_en1", 64'(lbuf1_en), 64'h1);

    // Reset while both slots armed.
    cyc(0, 64'h0, 0, 0, 0, 0, 1);
    chk("g_en", 64'({lbuf1_en, lbuf2_en}), 64'h0);
    chk("g_addr1", lbuf1_addr, 64'h0);
    chk("g_done", 64'(done_cnt), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 85) a[11:0] = 12'h000;
      cyc(logic'($urandom_range(0, 1)), a,
          logic'($urandom_range(0, 99) < 3),
          logic'($urandom_range(0, 99) < 5),
          logic'($urandom_range(0, 99) < 30),
          logic'($urandom_range(0, 99) < 30),
          logic'($urandom_range(0, 999) < 3));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
